mem_port_sched: RTL and testbench

//  Shares one single-port memory bus between CPU instruction fetch and CPU data access.

---
 rtl/mem_port_sched.sv | 158 +++++++++++++++
 tb/tb_mem_port_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_sched.sv
// Shares one single-port memory bus between CPU fetch and data access.
// One-entry fetch buffer, CPU stall generation and a bus watchdog.
module mem_port_sched #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_inst_addr,
    output logic [31:0] o_inst,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    input  logic [1:0]  i_data_rw,
    output logic        o_cpu_stall,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack,
    input  logic        i_err_clr,
    output logic        o_bus_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] INST = 2'd2;
    localparam logic [9:0] TMO  = 10'(TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_q, data_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] fbuf_addr_q, fbuf_addr_d;
    logic        fbuf_valid_q, fbuf_valid_d;
    logic        d_done_q, d_done_d;
    logic        err_q, err_d;
    logic [9:0]  wdog_q, wdog_d;

    logic        need_d, need_i, busy;
    logic        timeout, done;
    logic [31:0] rdata;

    assign need_d  = (i_data_rw != 2'b00) && !d_done_q;
    assign need_i  = !(fbuf_valid_q && fbuf_addr_q == i_inst_addr);
    assign busy    = (state_q != IDLE);
    assign timeout = busy && !i_mem_ack && (wdog_q == TMO);
    assign done    = busy && (i_mem_ack || timeout);
    // An aborted access completes as if the bus returned zero.
    assign rdata   = i_mem_ack ? i_mem_rdata : 32'd0;

    assign o_cpu_stall = busy || need_d || need_i;
    assign o_mem_req   = req_q;
    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_data      = data_q;
    assign o_inst      = inst_q;
    assign o_bus_err   = err_q;

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        data_d       = data_q;
        inst_d       = inst_q;
        fbuf_addr_d  = fbuf_addr_q;
        fbuf_valid_d = fbuf_valid_q;
        d_done_d     = d_done_q;
        err_d        = err_q;
        wdog_d       = wdog_q;
        if (i_err_clr) err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                wdog_d = 10'd0;
                if (!o_cpu_stall) d_done_d = 1'b0;
                if (need_d) begin
                    state_d = DATA;
                    req_d   = 1'b1;
                    we_d    = i_data_rw[1];
                    addr_d  = i_data_addr;
                    wdata_d = i_data;
                    wdog_d  = 10'd1;
                end else if (need_i) begin
                    state_d = INST;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = i_inst_addr;
                    wdog_d  = 10'd1;
                end
            end
            DATA, INST: begin
                if (done) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    wdog_d  = 10'd0;
                    if (timeout) err_d = 1'b1;
                    if (state_q == DATA) begin
                        d_done_d = 1'b1;
                        if (!we_q) begin
                            data_d = rdata;
                        end else if (addr_q == fbuf_addr_q) begin
                            fbuf_valid_d = 1'b0;
                        end
                    end else begin
                        fbuf_addr_d  = addr_q;
                        inst_d       = rdata;
                        fbuf_valid_d = 1'b1;
                    end
                end else begin
                    wdog_d = wdog_q + 10'd1;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                wdog_d  = 10'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            data_q       <= 32'd0;
            inst_q       <= 32'd0;
            fbuf_addr_q  <= 32'd0;
            fbuf_valid_q <= 1'b0;
            d_done_q     <= 1'b0;
            err_q        <= 1'b0;
            wdog_q       <= 10'd0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            data_q       <= data_d;
            inst_q       <= inst_d;
            fbuf_addr_q  <= fbuf_addr_d;
            fbuf_valid_q <= fbuf_valid_d;
            d_done_q     <= d_done_d;
            err_q        <= err_d;
            wdog_q       <= wdog_d;
        end
    end

endmodule

// File: tb/tb_mem_port_sched.sv
// Directed bench for mem_port_sched with a short watchdog.
module tb_mem_port_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_inst_addr;
    logic [31:0] o_inst;
    logic [31:0] i_data_addr;
    logic [31:0] i_data;
    logic [31:0] o_data;
    logic [1:0]  i_data_rw;
    logic        o_cpu_stall;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        i_mem_ack;
    logic        i_err_clr;
    logic        o_bus_err;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    mem_port_sched #(.TIMEOUT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_inst_addr (i_inst_addr),
        .o_inst      (o_inst),
        .i_data_addr (i_data_addr),
        .i_data      (i_data),
        .o_data      (o_data),
        .i_data_rw   (i_data_rw),
        .o_cpu_stall (o_cpu_stall),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_ack   (i_mem_ack),
        .i_err_clr   (i_err_clr),
        .o_bus_err   (o_bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b0;
        i_inst_addr = 32'h0;
        i_data_addr = 32'h0;
        i_data      = 32'h0;
        i_data_rw   = 2'b00;
        i_mem_rdata = 32'h0;
        i_mem_ack   = 1'b0;
        i_err_clr   = 1'b0;
        #1;
        chk("rst_req", o_mem_req, 0);
        chk("rst_we", o_mem_we, 0);
        chk("rst_addr", o_mem_addr, 0);
        chk("rst_wdata", o_mem_wdata, 0);
        chk("rst_data", o_data, 0);
        chk("rst_inst", o_inst, 0);
        chk("rst_err", o_bus_err, 0);
        chk("rst_stall", o_cpu_stall, 1);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("f0_stall0", o_cpu_stall, 1);

        // First fetch from 0x0, acked on its first req cycle
        step();
        chk("f0_req", o_mem_req, 1);
        chk("f0_addr", o_mem_addr, 32'h0);
        chk("f0_we", o_mem_we, 0);
        chk("f0_stall1", o_cpu_stall, 1);
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'h2408000A;
        step();
        i_mem_ack = 1'b0;
        #1;
        chk("f0_inst", o_inst, 32'h2408000A);
        chk("f0_req_off", o_mem_req, 0);
        chk("f0_stall2", o_cpu_stall, 0);
        step();
        chk("hit_req", o_mem_req, 0);
        chk("hit_stall", o_cpu_stall, 0);

        // Data read while fetch buffer hits
        i_data_rw   = 2'b01;
        i_data_addr = 32'h10000004;
        #1;
        chk("rd_stall0", o_cpu_stall, 1);
        step();
        chk("rd_req", o_mem_req, 1);
        chk("rd_we", o_mem_we, 0);
        chk("rd_addr", o_mem_addr, 32'h10000004);
        chk("rd_stall1", o_cpu_stall, 1);
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'hDEADBEEF;
        step();
        i_mem_ack = 1'b0;
        #1;
        chk("rd_data", o_data, 32'hDEADBEEF);
        chk("rd_req_off", o_mem_req, 0);
        chk("rd_stall2", o_cpu_stall, 0);
        i_data_rw = 2'b00;
        step();
        chk("rd_nofetch", o_mem_req, 0);
        chk("rd_idle", o_cpu_stall, 0);

        // Fetch 0x100, then write to 0x100 invalidates it
        i_inst_addr = 32'h100;
        #1;
        chk("f1_stall", o_cpu_stall, 1);
        step();
        chk("f1_addr", o_mem_addr, 32'h100);
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'h11111111;
        step();
        i_mem_ack = 1'b0;
        #1;
        chk("f1_inst", o_inst, 32'h11111111);
        chk("f1_stall2", o_cpu_stall, 0);
        i_data_rw   = 2'b10;
        i_data_addr = 32'h100;
        i_data      = 32'h0;
        #1;
        chk("wr_stall1", o_cpu_stall, 1);
        step();
        chk("wr_req", o_mem_req, 1);
        chk("wr_we", o_mem_we, 1);
        chk("wr_addr", o_mem_addr, 32'h100);
        chk("wr_wdata", o_mem_wdata, 32'h0);
        chk("wr_stall2", o_cpu_stall, 1);
        i_mem_ack = 1'b1;
        step();
        i_mem_ack = 1'b0;
        #1;
        chk("wr_req_off", o_mem_req, 0);
        chk("wr_stall3", o_cpu_stall, 1);
        step();
        chk("rf_req", o_mem_req, 1);
        chk("rf_we", o_mem_we, 0);
        chk("rf_addr", o_mem_addr, 32'h100);
        chk("wr_stall4", o_cpu_stall, 1);
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'h22222222;
        step();
        i_mem_ack = 1'b0;
        #1;
        chk("rf_inst", o_inst, 32'h22222222);
        chk("wr_stall5", o_cpu_stall, 0);
        i_data_rw = 2'b00;
        step();

        // Fetch that is never acked times out after 8 req cycles
        i_inst_addr = 32'h200;
        step();
        chk("to_req1", o_mem_req, 1);
        for (int i = 0; i < 7; i++) step();
        chk("to_req8", o_mem_req, 1);
        chk("to_stall8", o_cpu_stall, 1);
        chk("to_err8", o_bus_err, 0);
        step();
        chk("to_req_off", o_mem_req, 0);
        chk("to_inst", o_inst, 32'h0);
        chk("to_err", o_bus_err, 1);
        chk("to_stall", o_cpu_stall, 0);
        i_err_clr = 1'b1;
        step();
        i_err_clr = 1'b0;
        #1;
        chk("clr_err", o_bus_err, 0);

        // Ack lands on the timeout cycle: ack wins
        i_inst_addr = 32'h300;
        step();
        for (int i = 0; i < 7; i++) step();
        chk("at_req8", o_mem_req, 1);
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'h33333333;
        step();
        i_mem_ack = 1'b0;
        #1;
        chk("at_inst", o_inst, 32'h33333333);
        chk("at_err", o_bus_err, 0);
        chk("at_req_off", o_mem_req, 0);

        // Reset in the middle of a data access
        i_data_rw   = 2'b01;
        i_data_addr = 32'h44;
        step();
        chk("mr_req", o_mem_req, 1);
        rst = 1'b0;
        #1;
        chk("mr_req_drop", o_mem_req, 0);
        chk("mr_inst", o_inst, 32'h0);
        chk("mr_stall", o_cpu_stall, 1);
        i_data_rw = 2'b00;
        step();
        rst = 1'b1;
        #1;
        chk("mr_stall1", o_cpu_stall, 1);
        step();
        chk("mr_freq", o_mem_req, 1);
        chk("mr_faddr", o_mem_addr, 32'h300);
        chk("mr_stall2", o_cpu_stall, 1);
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'h55555555;
        step();
        i_mem_ack = 1'b0;
        #1;
        chk("mr_inst2", o_inst, 32'h55555555);
        chk("mr_stall3", o_cpu_stall, 0);

        // Stray ack while idle must be ignored
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'h99999999;
        step();
        i_mem_ack = 1'b0;
        #1;
        chk("ia_inst", o_inst, 32'h55555555);
        chk("ia_req", o_mem_req, 0);
        chk("ia_stall", o_cpu_stall, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
